// File: rtl/nr_iter_sequencer.sv
// Run-control FSM for the Newton-Raphson / Broyden datapath: issues one-cycle
// start strobes to the F, mat-vec and Broyden units and counts iterations.
module nr_iter_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_cycles,
    output logic             init_load,
    output logic             f_start,
    input  logic             f_done,
    output logic             mv_start,
    input  logic             mv_done,
    output logic             xupd_en,
    output logic             g_start,
    input  logic             g_done,
    output logic [CNT_W-1:0] iter_count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_F0, S_WF0, S_MV, S_WMV,
        S_UPDX, S_F, S_WF, S_G, S_WG, S_DONE
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      tmo_q, tmo_d;
    logic [CNT_W-1:0] ncyc_q, ncyc_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] iter_inc;
    logic             err_q, err_d;
    logic             in_wait;
    logic             resp;

    assign iter_inc   = iter_q + CNT_W'(1);
    assign iter_count = iter_q;
    assign err        = err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        tmo_d   = tmo_q;
        ncyc_d  = ncyc_q;
        iter_d  = iter_q;
        err_d   = err_q;
        in_wait = 1'b0;
        resp    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d = S_INIT;
                    ncyc_d  = num_cycles;
                    iter_d  = '0;
                    err_d   = 1'b0;
                end
                S_INIT: state_d = (ncyc_q == '0) ? S_DONE : S_F0;
                S_F0: begin
                    state_d = S_WF0;
                    tmo_d   = '0;
                end
                S_WF0: begin
                    in_wait = 1'b1;
                    resp    = f_done;
                    if (f_done) state_d = S_MV;
                end
                S_MV: begin
                    state_d = S_WMV;
                    tmo_d   = '0;
                end
                S_WMV: begin
                    in_wait = 1'b1;
                    resp    = mv_done;
                    if (mv_done) state_d = S_UPDX;
                end
                S_UPDX: state_d = S_F;
                S_F: begin
                    state_d = S_WF;
                    tmo_d   = '0;
                end
                S_WF: begin
                    in_wait = 1'b1;
                    resp    = f_done;
                    if (f_done) state_d = S_G;
                end
                S_G: begin
                    state_d = S_WG;
                    tmo_d   = '0;
                end
                S_WG: begin
                    in_wait = 1'b1;
                    resp    = g_done;
                    if (g_done) begin
                        iter_d  = iter_inc;
                        state_d = (iter_inc == ncyc_q) ? S_DONE : S_MV;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            // A done landing on the last allowed wait cycle still wins over the timeout.
            if (in_wait && !resp) begin
                if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
        end
    end

    // Strobes are decoded from the next state so they appear registered, aligned with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            ncyc_q    <= '0;
            iter_q    <= '0;
            err_q     <= 1'b0;
            init_load <= 1'b0;
            f_start   <= 1'b0;
            mv_start  <= 1'b0;
            xupd_en   <= 1'b0;
            g_start   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            ncyc_q    <= ncyc_d;
            iter_q    <= iter_d;
            err_q     <= err_d;
            init_load <= (state_d == S_INIT);
            f_start   <= (state_d == S_F0) || (state_d == S_F);
            mv_start  <= (state_d == S_MV);
            xupd_en   <= (state_d == S_UPDX);
            g_start   <= (state_d == S_G);
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

endmodule

// File: doc/nr_iter_sequencer.md
Name: nr_iter_sequencer

Overview:
Control FSM that sequences the Newton-Raphson / Broyden datapath through a run of num_cycles iterations.
- Issues one-cycle start pulses to the F-evaluation unit (done = stbf), the inverse-Jacobian mat-vec unit, and the Broyden inverse-Jacobian update unit (done = stbg).
- Pulses register-load enables for x and F_old, and counts iterations.
- Sits between the top-level run control (start / num_cycles) and the 3-variable fp32 datapath.
- Carries no data, only control.

Parameters:
TIMEOUT, 255, max cycles spent in any WAIT state before err; valid range 1..65535.
CNT_W, 6, width of num_cycles and iter_count.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  synchronous abort; any state -> IDLE
num_cycles  in  CNT_W  iterations to run; captured when start is accepted
init_load  out  1  load in_x0..2 into x and load the initial invJ
f_start  out  1  start F(x) evaluation
f_done  in  1  stbf from the F unit
mv_start  out  1  start dx = -invJ*F
mv_done  in  1  mat-vec complete
xupd_en  out  1  x <= x + dx; F_old <= F; dx saved
g_start  out  1  start Broyden invJ update
g_done  in  1  stbg from the Broyden unit
iter_count  out  CNT_W  completed iterations
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at normal completion
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; iter_count=0; timeout counter=0; captured num_cycles=0.
- States: IDLE, INIT, F0, WF0, MV, WMV, UPDX, F, WF, G, WG, DONE.
- IDLE: start=1 -> INIT. On acceptance: capture num_cycles, clear iter_count, clear err.
- INIT: init_load=1 for one cycle. Next state is F0, or DONE if num_cycles==0.
- F0: f_start=1 for one cycle -> WF0.
- WF0: wait for f_done -> MV.
- MV: mv_start=1 -> WMV.
- WMV: wait for mv_done -> UPDX.
- UPDX: xupd_en=1 for one cycle -> F.
- F: f_start=1 -> WF.
- WF: wait for f_done -> G.
- G: g_start=1 -> WG.
- WG: on g_done, iter_count <= iter_count+1. Next is DONE if the new count equals captured num_cycles, else MV.
- DONE: done=1 for one cycle -> IDLE. busy is high in DONE.
- Strobes are Moore outputs, exactly one cycle per issue state; never two in the same cycle.
- Done inputs are honoured only in the matching WAIT state. They are ignored in issue states and all other states (no queuing), so units need ≥1 cycle latency.
- Timeout counter clears on entry to each WAIT state and increments each cycle there. When it reaches TIMEOUT without the matching done: err <= 1, state -> IDLE, no done pulse.
- A done arriving in the same cycle the count reaches TIMEOUT counts as success.
- err stays high until the next accepted start or reset.
- abort=1 in any state: next state IDLE, all strobes 0, no done pulse. iter_count and err hold. abort has priority over start and over done inputs.
- start while busy: ignored. Changes to num_cycles while busy: ignored.
- iter_count saturates implicitly, because captured num_cycles ≤ 2^CNT_W-1 and the terminal compare stops it.
- Timing with every unit answering on the first WAIT cycle:
  - start sampled at cycle 0; INIT at c1; F0 at c2; first MV at c4.
  - Each iteration takes 7 cycles (MV..WG).
  - done asserts at cycle 4 + 7*num_cycles.
  - num_cycles==0: done at c2.

Test Plan:
- Reset mid-run: rst=0 while in WMV -> all outputs 0 and state IDLE immediately, without waiting for a clock edge. After release, start runs normally.
- Nominal run, 1-cycle responders, num_cycles=5, start pulse at c0:
  - init_load at c1; f_start at c2, c7, c14, c21, c28, c35.
  - done at c39; iter_count=5; g_start count=5, mv_start count=5, xupd_en count=5.
- num_cycles=0 -> init_load at c1; done at c2; no f_start, mv_start or g_start; iter_count=0.
- Timeout: TIMEOUT=8, f_done never asserted -> err=1 on the 8th WF0 cycle; then IDLE, no done. The next start clears err.
- Spurious strobes: f_done, mv_done and g_done asserted during F0, MV, G and IDLE -> no state advance. A second start while busy is ignored, and iteration timing is unchanged vs nominal.
- Abort: abort=1 during WG of iteration 3 -> IDLE next cycle, iter_count holds 2, no done, busy=0.
